mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access pipeline stage sitting directly upstream of writeback; consumes EX results and produces registered WB-stage inputs.
- Performs loads and stores over a variable-latency req/ack data-memory bus, with byte/halfword lane steering, load sign/zero extension and alignment checking.
- Stalls the upstream pipeline while a bus transaction is outstanding.

Parameters:
- W, 32, datapath/word width (`WORD_WIDTH); byte-lane logic fixed for W=32.
- SRC_W, 2, width of reg_write_src (`REG_W_SRC_WIDTH).
- RA_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX stage presents an instruction
- in_ready  out  1  stage can accept this cycle (0 = stall upstream)
- mem_read  in  1  load
- mem_write  in  1  store
- mem_size  in  2  00 byte, 01 half, 10/11 word
- mem_unsigned  in  1  zero-extend loads (else sign-extend)
- alu_result  in  W  ALU result / effective address
- store_data  in  W  rt value for stores
- pc  in  W  instruction PC
- imm  in  W  immediate
- reg_write  in  1  instruction writes a register
- reg_write_src  in  SRC_W  writeback source select, passed through
- rd  in  RA_W  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  W  word-aligned address (addr[1:0]=00)
- dmem_wdata  out  W  lane-replicated store data
- dmem_be  out  4  byte enables, bit i = bits 8i+7:8i
- dmem_ack  in  1  bus completes this cycle
- dmem_rdata  in  W  read data, valid when dmem_ack=1
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_reg_write, wb_alu_result, wb_mem_data, wb_pc, wb_imm, wb_reg_write_src, wb_rd  out  1/W/W/W/W/SRC_W/RA_W  registered writeback inputs
- addr_err  out  1  one-cycle pulse: misaligned access

Behaviour:
- Reset: state IDLE; every output register 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, all wb_*, addr_err). in_ready = 1 in IDLE.
- FSM has two states, IDLE and BUSY. in_ready = (state == IDLE).
- Acceptance happens at an edge with IDLE and in_valid=1. All inputs are latched at that edge.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠00, when mem_read or mem_write is set.
- IDLE, accept, no memory op (or misaligned):
  - next edge: wb_valid=1, wb_* = latched inputs, wb_mem_data=0; stay IDLE; latency 1.
  - misaligned: additionally addr_err=1 and wb_reg_write=0; no bus access.
- IDLE, accept, aligned memory op:
  - go BUSY and drive dmem_req=1, dmem_we=mem_write, dmem_addr={addr[W-1:2],2'b00}.
  - dmem_be: byte → 0001<<addr[1:0]; half → 0011<<addr[1:0]; word → 1111; loads use the same be.
  - dmem_wdata: byte → {4{sd[7:0]}}; half → {2{sd[15:0]}}; word → sd.
- BUSY: request signals held stable until dmem_ack=1 is sampled. At that edge:
  - dmem_req=0, dmem_be=0, state IDLE, wb_valid=1.
  - load: wb_mem_data = selected lane (little-endian, byte lane addr[1:0], half lane addr[1]), sign- or zero-extended to W.
  - store: wb_mem_data=0.
  - Minimum memory latency 2 cycles (accept edge + ack edge); arbitrary wait states allowed.
- dmem_ack while IDLE is ignored.
- mem_read and mem_write both set: treated as a store; wb_reg_write passed through unchanged.
- wb_valid and addr_err are single-cycle pulses. wb_reg_write is 0 whenever wb_valid=0; other wb_* hold last values.
- Back-to-back accepts are allowed in IDLE after any retire edge, so one instruction per cycle is possible for non-memory ops.
- Reset asserted mid-BUSY: dmem_req drops asynchronously, pending instruction is discarded, no wb_valid.

Test Plan:
- Reset, then ALU op (alu_result=0x1234, reg_write=1, rd=5) → next cycle wb_valid=1, wb_alu_result=0x1234, wb_rd=5, in_ready stays 1.
- lb, addr=0x103, mem_unsigned=0, ack after 3 wait cycles, rdata=0x80AA55CC → dmem_addr=0x100, be=1000, in_ready=0 for 4 cycles, wb_mem_data=0xFFFFFF80.
- lhu, addr=0x102, rdata=0x80AA55CC, ack same cycle as req → be=1100, wb_mem_data=0x000080AA, wb_valid 2 cycles after accept.
- sb, addr=0x201, store_data=0x12345678 → dmem_we=1, be=0010, wdata=0x78787878, wb_mem_data=0.
- lw, addr=0x302 → addr_err=1, wb_valid=1, wb_reg_write=0, dmem_req never asserted.
- sw started then rst pulsed during BUSY with no ack → dmem_req=0 immediately, state IDLE, no wb_valid after reset release.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory-access stage with req/ack data bus, lane steering, load extension and alignment check
module mem_access #(
   parameter int W     = 32,
   parameter int SRC_W = 2,
   parameter int RA_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [1:0]       mem_size,
   input  logic             mem_unsigned,
   input  logic [W-1:0]     alu_result,
   input  logic [W-1:0]     store_data,
   input  logic [W-1:0]     pc,
   input  logic [W-1:0]     imm,
   input  logic             reg_write,
   input  logic [SRC_W-1:0] reg_write_src,
   input  logic [RA_W-1:0]  rd,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [W-1:0]     dmem_addr,
   output logic [W-1:0]     dmem_wdata,
   output logic [3:0]       dmem_be,
   input  logic             dmem_ack,
   input  logic [W-1:0]     dmem_rdata,
   output logic             wb_valid,
   output logic             wb_reg_write,
   output logic [W-1:0]     wb_alu_result,
   output logic [W-1:0]     wb_mem_data,
   output logic [W-1:0]     wb_pc,
   output logic [W-1:0]     wb_imm,
   output logic [SRC_W-1:0] wb_reg_write_src,
   output logic [RA_W-1:0]  wb_rd,
   output logic             addr_err
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t r_state, w_next;
   logic             w_accept, w_memop, w_mis, w_go, w_done;
   logic [3:0]       w_be;
   logic [W-1:0]     w_wdata, w_ld;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [1:0]       r_lane, r_size;
   logic             r_uns, r_load, r_rw;
   logic [W-1:0]     r_alu, r_pc, r_imm;
   logic [SRC_W-1:0] r_src;
   logic [RA_W-1:0]  r_rd;
   assign in_ready = (r_state == IDLE);
   // Decode the incoming instruction and steer the returning read lane
   always_comb begin
      w_accept = in_ready && in_valid;
      w_memop  = mem_read || mem_write;
      w_mis    = w_memop && ((mem_size == 2'b01 && alu_result[0]) ||
                             (mem_size[1] && alu_result[1:0] != 2'b00));
      w_go     = w_accept && w_memop && !w_mis;
      w_done   = (r_state == BUSY) && dmem_ack;
      w_be     = (mem_size == 2'b00) ? 4'b0001 << alu_result[1:0] :
                 (mem_size == 2'b01) ? 4'b0011 << alu_result[1:0] : 4'b1111;
      w_wdata  = (mem_size == 2'b00) ? {4{store_data[7:0]}} :
                 (mem_size == 2'b01) ? {2{store_data[15:0]}} : store_data;
      w_byte   = dmem_rdata[{r_lane, 3'b000} +: 8];
      w_half   = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      w_ld     = (r_size == 2'b00) ? {{(W-8){~r_uns & w_byte[7]}}, w_byte} :
                 (r_size == 2'b01) ? {{(W-16){~r_uns & w_half[15]}}, w_half} : dmem_rdata;
   end
   // Next state: IDLE launches aligned memory ops, BUSY waits for the ack
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE) ? (w_go ? BUSY : IDLE) : (dmem_ack ? IDLE : BUSY);
   end
   // State register
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   // Hold the accepted instruction until its bus transaction retires
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_lane <= '0;
         r_size <= '0;
         r_uns  <= 1'b0;
         r_load <= 1'b0;
         r_rw   <= 1'b0;
         r_alu  <= '0;
         r_pc   <= '0;
         r_imm  <= '0;
         r_src  <= '0;
         r_rd   <= '0;
      end else if (w_accept) begin
         r_lane <= alu_result[1:0];
         r_size <= mem_size;
         r_uns  <= mem_unsigned;
         r_load <= mem_read && !mem_write;
         r_rw   <= reg_write;
         r_alu  <= alu_result;
         r_pc   <= pc;
         r_imm  <= imm;
         r_src  <= reg_write_src;
         r_rd   <= rd;
      end
   // Bus request and writeback registers; pulses default low every cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         dmem_req         <= 1'b0;
         dmem_we          <= 1'b0;
         dmem_addr        <= '0;
         dmem_wdata       <= '0;
         dmem_be          <= '0;
         wb_valid         <= 1'b0;
         wb_reg_write     <= 1'b0;
         wb_alu_result    <= '0;
         wb_mem_data      <= '0;
         wb_pc            <= '0;
         wb_imm           <= '0;
         wb_reg_write_src <= '0;
         wb_rd            <= '0;
         addr_err         <= 1'b0;
      end else begin
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         addr_err     <= 1'b0;
         if (w_accept && !w_go) begin
            wb_valid         <= 1'b1;
            wb_reg_write     <= reg_write && !w_mis;
            addr_err         <= w_mis;
            wb_alu_result    <= alu_result;
            wb_mem_data      <= '0;
            wb_pc            <= pc;
            wb_imm           <= imm;
            wb_reg_write_src <= reg_write_src;
            wb_rd            <= rd;
         end
         if (w_go) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {alu_result[W-1:2], 2'b00};
            dmem_be    <= w_be;
            dmem_wdata <= w_wdata;
         end
         if (w_done) begin
            dmem_req         <= 1'b0;
            dmem_be          <= '0;
            wb_valid         <= 1'b1;
            wb_reg_write     <= r_rw;
            wb_alu_result    <= r_alu;
            wb_mem_data      <= r_load ? w_ld : '0;
            wb_pc            <= r_pc;
            wb_imm           <= r_imm;
            wb_reg_write_src <= r_src;
            wb_rd            <= r_rd;
         end
      end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven bench with a writeback scoreboard for mem_access
module tb_mem_access;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic        mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0, reg_write = 1'b0;
   logic [1:0]  mem_size = '0, reg_write_src = '0;
   logic [31:0] alu_result = '0, store_data = '0, pc = '0, imm = '0;
   logic [4:0]  rd = '0;
   logic        dmem_req, dmem_we, dmem_ack = 1'b0;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_reg_write, addr_err;
   logic [31:0] wb_alu_result, wb_mem_data, wb_pc, wb_imm;
   logic [1:0]  wb_reg_write_src;
   logic [4:0]  wb_rd;

   int n_checks = 0, n_fail = 0;

   typedef struct {
      logic rd, wr; logic [1:0] sz; logic uns; logic [31:0] addr, sd; logic rw; logic [4:0] rdx;
      int waits; logic [31:0] rdata; logic bus; logic [31:0] eaddr; logic [3:0] ebe;
      logic [31:0] ewd, emem; logic eerr, erw;
   } vec_t;
   typedef struct {
      logic [31:0] alu, mem, pc, imm; logic [1:0] src; logic [4:0] rd; logic rw, err;
   } exp_t;

   vec_t tv[14];
   exp_t sb[$];

   mem_access dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
      .alu_result(alu_result), .store_data(store_data), .pc(pc), .imm(imm),
      .reg_write(reg_write), .reg_write_src(reg_write_src), .rd(rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_alu_result(wb_alu_result),
      .wb_mem_data(wb_mem_data), .wb_pc(wb_pc), .wb_imm(wb_imm),
      .wb_reg_write_src(wb_reg_write_src), .wb_rd(wb_rd), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every retire is popped and compared; quiet cycles must keep pulses low
   always begin
      @(posedge clk);
      #1;
      if (wb_valid) begin
         if (sb.size() == 0) chk("unexpected_wb_valid", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_alu_result", wb_alu_result, e.alu);
            chk("wb_mem_data", wb_mem_data, e.mem);
            chk("wb_pc", wb_pc, e.pc);
            chk("wb_imm", wb_imm, e.imm);
            chk("wb_reg_write_src", {30'd0, wb_reg_write_src}, {30'd0, e.src});
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
            chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
         end
      end else begin
         chk("idle_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
         chk("idle_addr_err", {31'd0, addr_err}, 32'd0);
      end
   end

   task automatic drive(input vec_t v, input int i);
      mem_read = v.rd; mem_write = v.wr; mem_size = v.sz; mem_unsigned = v.uns;
      alu_result = v.addr; store_data = v.sd; reg_write = v.rw; rd = v.rdx;
      pc = 32'h1000 + 32'(i * 4); imm = 32'(i) * 32'h11; reg_write_src = 2'(i);
      in_valid = 1'b1;
      sb.push_back('{v.addr, v.emem, pc, imm, reg_write_src, v.rdx, v.erw, v.eerr});
   endtask

   task automatic run(input vec_t v, input int i);
      @(negedge clk);
      drive(v, i);
      @(negedge clk);
      in_valid = 1'b0;
      if (v.bus) begin
         chk("dmem_req", {31'd0, dmem_req}, 32'd1);
         chk("dmem_addr", dmem_addr, v.eaddr);
         chk("dmem_be", {28'd0, dmem_be}, {28'd0, v.ebe});
         chk("dmem_we", {31'd0, dmem_we}, {31'd0, v.wr});
         if (v.wr) chk("dmem_wdata", dmem_wdata, v.ewd);
         chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
         for (int w = 0; w < v.waits; w++) begin
            @(negedge clk);
            chk("wait_dmem_req", {31'd0, dmem_req}, 32'd1);
            chk("wait_dmem_be", {28'd0, dmem_be}, {28'd0, v.ebe});
            chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
         end
         dmem_ack = 1'b1;
         dmem_rdata = v.rdata;
         @(negedge clk);
         dmem_ack = 1'b0;
         dmem_rdata = 32'h0BAD0BAD;
         chk("post_ack_req", {31'd0, dmem_req}, 32'd0);
         chk("post_ack_be", {28'd0, dmem_be}, 32'd0);
      end else
         chk("no_bus_req", {31'd0, dmem_req}, 32'd0);
      chk("ready_after", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      tv[0]  = '{1'b0,1'b0,2'd2,1'b0,32'h1234,32'h0,1'b1,5'd5,0,32'h0,1'b0,32'h0,4'h0,32'h0,32'h0,1'b0,1'b1};
      tv[1]  = '{1'b1,1'b0,2'd0,1'b0,32'h103,32'h0,1'b1,5'd6,3,32'h80AA55CC,1'b1,32'h100,4'b1000,32'h0,32'hFFFFFF80,1'b0,1'b1};
      tv[2]  = '{1'b1,1'b0,2'd1,1'b1,32'h102,32'h0,1'b1,5'd7,0,32'h80AA55CC,1'b1,32'h100,4'b1100,32'h0,32'h000080AA,1'b0,1'b1};
      tv[3]  = '{1'b0,1'b1,2'd0,1'b0,32'h201,32'h12345678,1'b0,5'd0,1,32'h0,1'b1,32'h200,4'b0010,32'h78787878,32'h0,1'b0,1'b0};
      tv[4]  = '{1'b1,1'b0,2'd2,1'b0,32'h302,32'h0,1'b1,5'd8,0,32'h0,1'b0,32'h0,4'h0,32'h0,32'h0,1'b1,1'b0};
      tv[5]  = '{1'b1,1'b0,2'd1,1'b0,32'h100,32'h0,1'b1,5'd9,1,32'h12348001,1'b1,32'h100,4'b0011,32'h0,32'hFFFF8001,1'b0,1'b1};
      tv[6]  = '{1'b1,1'b0,2'd0,1'b1,32'h102,32'h0,1'b1,5'd10,0,32'h11FE2233,1'b1,32'h100,4'b0100,32'h0,32'h000000FE,1'b0,1'b1};
      tv[7]  = '{1'b0,1'b1,2'd1,1'b0,32'h306,32'hAAAABEEF,1'b0,5'd0,2,32'h0,1'b1,32'h304,4'b1100,32'hBEEFBEEF,32'h0,1'b0,1'b0};
      tv[8]  = '{1'b1,1'b0,2'd3,1'b0,32'h400,32'h0,1'b1,5'd11,0,32'hDEADBEEF,1'b1,32'h400,4'b1111,32'h0,32'hDEADBEEF,1'b0,1'b1};
      tv[9]  = '{1'b1,1'b1,2'd2,1'b0,32'h404,32'hCAFEF00D,1'b1,5'd12,1,32'h55555555,1'b1,32'h404,4'b1111,32'hCAFEF00D,32'h0,1'b0,1'b1};
      tv[10] = '{1'b1,1'b0,2'd1,1'b0,32'h105,32'h0,1'b1,5'd13,0,32'h0,1'b0,32'h0,4'h0,32'h0,32'h0,1'b1,1'b0};
      tv[11] = '{1'b0,1'b0,2'd2,1'b0,32'h3,32'h0,1'b1,5'd14,0,32'h0,1'b0,32'h0,4'h0,32'h0,32'h0,1'b0,1'b1};
      tv[12] = '{1'b1,1'b0,2'd0,1'b0,32'h500,32'h0,1'b1,5'd15,0,32'hFFFFFF7F,1'b1,32'h500,4'b0001,32'h0,32'h0000007F,1'b0,1'b1};
      tv[13] = '{1'b0,1'b1,2'd2,1'b0,32'h601,32'h9,1'b1,5'd16,0,32'h0,1'b0,32'h0,4'h0,32'h0,32'h0,1'b1,1'b0};

      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_wb_mem_data", wb_mem_data, 32'd0);
      chk("rst_dmem_addr", dmem_addr, 32'd0);
      rst = 1'b0;

      foreach (tv[i]) run(tv[i], i);

      // back-to-back ALU ops, one per cycle
      @(negedge clk);
      drive(tv[0], 20);
      @(negedge clk);
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
      drive(tv[11], 21);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_ready2", {31'd0, in_ready}, 32'd1);

      // ack while idle must be ignored
      dmem_ack = 1'b1;
      repeat (2) @(negedge clk);
      dmem_ack = 1'b0;
      chk("idle_ack_req", {31'd0, dmem_req}, 32'd0);
      chk("idle_ack_ready", {31'd0, in_ready}, 32'd1);

      // store abandoned by reset while BUSY
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b1; mem_size = 2'd2; alu_result = 32'h700;
      store_data = 32'h1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; mem_write = 1'b0;
      chk("sw_req_before_rst", {31'd0, dmem_req}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_async_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_rst_req", {31'd0, dmem_req}, 32'd0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
